filtr_dac_out: RTL and testbench

Downstream stage of filtr_top. Captures each filtered sample when the filter signals completion and truncates it to DAC width. Serialises it MSB-first to an external SPI-style DAC using SCLK, SDATA and a SYNC_n frame. A one-sample holding register decouples filter completion from the serial frame in progress.

---
 rtl/filtr_dac_out.sv | 185 ++++++++++++++++++
 tb/tb_filtr_dac_out.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filtr_dac_out.sv
// filtr_dac_out: captures each filtered sample on the rising edge of
// data_valid, truncates it to its upper DAC_BITS and shifts it MSB-first
// to an SPI-style DAC framed by dac_sync_n. A one-word holding register
// lets the next sample arrive while the current frame is still shifting.
// Build option: define FILTR_DAC_OFFSET_BIN_EN to send offset binary
// (MSB inverted) instead of two's complement.
module filtr_dac_out #(
  parameter int unsigned DATA_SIZE = 24,
  parameter int unsigned DAC_BITS  = 16,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 data_valid,
  output logic                 dac_sclk,
  output logic                 dac_sdata,
  output logic                 dac_sync_n,
  output logic                 busy,
  output logic                 overrun
);

  // div_cnt spans both the SCLK half-period and the 2*CLK_DIV inter-frame gap
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DAC_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DAC_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [DAC_BITS-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                dv_q, dv_d;
  logic [DAC_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                sync_n_q, sync_n_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  logic [DAC_BITS-1:0] cap_word_c;
  logic                capture_c;
  logic                consume_c;

  // Low-order sample bits are dropped by truncation
  if (DATA_SIZE > DAC_BITS) begin : g_trunc
    logic unused_lsb_c;
    assign unused_lsb_c = ^data_in[DATA_SIZE-DAC_BITS-1:0];
  end

  // Truncated word as it will be sent; optional two's complement -> offset binary
  always_comb begin
    cap_word_c = data_in[DATA_SIZE-1 -: DAC_BITS];
`ifdef FILTR_DAC_OFFSET_BIN_EN
    cap_word_c[DAC_BITS-1] = ~cap_word_c[DAC_BITS-1];
`endif
  end

  assign capture_c = data_valid & ~dv_q;
  assign consume_c = (state_q == ST_IDLE) & hold_full_q;

  // State register; synchronous active-low reset aborts any frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      dv_q        <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sync_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      dv_q        <= dv_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      sync_n_q    <= sync_n_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state: holding register, frame sequencer and serial outputs
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    dv_d        = data_valid;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    sclk_d      = sclk_q;
    sdata_d     = sdata_q;
    sync_n_d    = sync_n_q;
    overrun_d   = overrun_q;

    // A capture always wins the holding register; losing an unsent word is sticky
    if (capture_c) begin
      hold_d      = cap_word_c;
      hold_full_d = 1'b1;
      if (hold_full_q && !consume_c) begin
        overrun_d = 1'b1;
      end
    end else if (consume_c) begin
      hold_full_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shreg_d   = hold_q;
          sdata_d   = hold_q[DAC_BITS-1];
          sync_n_d  = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling SCLK: either present the next bit or close the frame
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              sync_n_d = 1'b1;
              state_d  = ST_GAP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              shreg_d   = shreg_q << 1;
              sdata_d   = shreg_q[DAC_BITS-2];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (div_cnt_q == GAP_LAST) begin
          div_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) | hold_full_d;
  end

  assign dac_sclk   = sclk_q;
  assign dac_sdata  = sdata_q;
  assign dac_sync_n = sync_n_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_filtr_dac_out.sv
// Self-checking bench for filtr_dac_out (defaults 24/16/4). Expected frames,
// busy and overrun come from a cycle-count model of the sample flow; the DAC
// side is decoded from the pins and compared against it and a vector table.
module tb_filtr_dac_out;

  localparam int DS    = 24;
  localparam int DB    = 16;
  localparam int CD    = 4;
  localparam int FRAME = DB * 2 * CD;
  localparam int GAP   = 2 * CD;

  logic          clk = 1'b0;
  logic          reset;
  logic [DS-1:0] data_in;
  logic          data_valid;
  logic          dac_sclk, dac_sdata, dac_sync_n, busy, overrun;

  filtr_dac_out #(.DATA_SIZE(DS), .DAC_BITS(DB), .CLK_DIV(CD)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .dac_sclk  (dac_sclk),
    .dac_sdata (dac_sdata),
    .dac_sync_n(dac_sync_n),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  // model of the sample flow
  typedef struct { logic [DB-1:0] w; int start; } frame_t;
  frame_t        expq[$];
  bit            m_dv_q = 1'b0;
  bit            m_full = 1'b0;
  bit            m_ovr  = 1'b0;
  logic [DB-1:0] m_hold = '0;
  int            m_free = 0;

  // pin decoder
  bit            in_frame = 1'b0;
  int            f_start, f_n;
  logic [DB-1:0] f_bits;
  int            last_end = -1;
  logic          p_sclk = 1'b0, p_sdata = 1'b0;
  logic [DB-1:0] obs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (edge %0d)", name, got, exp, ecount);
    end
  endtask

  // Word the DAC should receive for a given filter sample
  function automatic logic [DB-1:0] tw(input logic [DB-1:0] twos);
`ifdef FILTR_DAC_OFFSET_BIN_EN
    return twos ^ 16'h8000;
`else
    return twos;
`endif
  endfunction

  function automatic logic [DB-1:0] to_word(input logic [DS-1:0] d);
    return tw(d[DS-1:DS-DB]);
  endfunction

  task automatic decode();
    frame_t f;
    if (in_frame) begin
      if (dac_sclk && !p_sclk) begin
        check("sdata_stable_at_rise", 32'(dac_sdata), 32'(p_sdata));
        f_bits = {f_bits[DB-2:0], dac_sdata};
        f_n++;
      end
      if (dac_sync_n) begin
        in_frame = 1'b0;
        last_end = ecount;
        obs.push_back(f_bits);
        check("bits_per_frame", 32'(f_n), 32'(DB));
        check("sync_low_len", 32'(ecount - f_start), 32'(FRAME));
        check("frame_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          f = expq.pop_front();
          check("frame_word", 32'(f_bits), 32'(f.w));
          check("frame_start", 32'(f_start), 32'(f.start));
        end
      end
    end else begin
      check("idle_sclk", 32'(dac_sclk), 32'd0);
      if (!dac_sync_n) begin
        in_frame = 1'b1;
        f_start  = ecount;
        f_bits   = '0;
        f_n      = 0;
        if (last_end >= 0) check("gap_min", 32'((ecount - last_end) >= GAP), 32'd1);
      end
    end
  endtask

  // One clock: drive, step the model at the edge, check at the falling edge
  task automatic tick(input bit rst, input bit dv, input logic [DS-1:0] din);
    bit cap, con;
    reset      = rst;
    data_valid = dv;
    data_in    = din;
    @(posedge clk);
    ecount++;
    if (!rst) begin
      m_dv_q = 1'b0;
      m_full = 1'b0;
      m_ovr  = 1'b0;
      m_hold = '0;
      m_free = ecount + 1;
      expq.delete();
    end else begin
      cap = dv && !m_dv_q;
      con = m_full && (ecount >= m_free);
      if (con) begin
        expq.push_back('{w: m_hold, start: ecount});
        m_free = ecount + 1 + FRAME + GAP;
      end
      if (cap) begin
        if (m_full && !con) m_ovr = 1'b1;
        m_hold = to_word(din);
        m_full = 1'b1;
      end else if (con) begin
        m_full = 1'b0;
      end
      m_dv_q = dv;
    end
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_full || (ecount < m_free - 1)));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (!rst) begin
      in_frame = 1'b0;
      last_end = -1;
      check("rst_sync_n", 32'(dac_sync_n), 32'd1);
      check("rst_sclk", 32'(dac_sclk), 32'd0);
      check("rst_sdata", 32'(dac_sdata), 32'd0);
    end else begin
      decode();
    end
    p_sclk  = dac_sclk;
    p_sdata = dac_sdata;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_full || ecount < m_free || in_frame) && n < 5000) begin
      tick(1'b1, 1'b0, 24'($urandom));
      n++;
    end
    check("drain_in_budget", 32'(n < 5000), 32'd1);
    repeat (3) tick(1'b1, 1'b0, 24'h0);
    check("pending_frames", 32'(expq.size()), 32'd0);
  endtask

  typedef struct {
    logic [DS-1:0] d0, d1, d2;
    int            n, off1, off2;
    bit            hold;
    int            nexp;
    logic [DB-1:0] w0, w1, w2;
    bit            ovr;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  initial begin
    int span, gap, wid;
    bit dv;
    logic [DS-1:0] d;

    // d0 d1 d2 / captures, offsets from first capture / held-high / frames / ovr
    vt[0] = '{24'h123456, 24'h0, 24'h0, 1, 0, 0, 1'b0, 1, 16'h1234, 16'h0, 16'h0, 1'b0};
    vt[1] = '{24'hABCDEF, 24'h0, 24'h0, 1, 0, 0, 1'b1, 1, 16'hABCD, 16'h0, 16'h0, 1'b0};
    vt[2] = '{24'h111111, 24'h222222, 24'h0, 2, 40, 0, 1'b0, 2, 16'h1111, 16'h2222, 16'h0, 1'b0};
    vt[3] = '{24'h111111, 24'h222222, 24'h333333, 3, 40, 80, 1'b0, 2, 16'h1111, 16'h3333, 16'h0, 1'b1};
    vt[4] = '{24'h800000, 24'h0, 24'h0, 1, 0, 0, 1'b0, 1, 16'h8000, 16'h0, 16'h0, 1'b0};
    vt[5] = '{24'h7FFFFF, 24'h0, 24'h0, 1, 0, 0, 1'b0, 1, 16'h7FFF, 16'h0, 16'h0, 1'b0};
    // third capture one edge before the hold is consumed -> second word lost
    vt[6] = '{24'hA5A5A5, 24'h5A5A5A, 24'h0F0F0F, 3, 40, 137, 1'b0, 2, 16'hA5A5, 16'h0F0F, 16'h0, 1'b1};
    // third capture on the very edge the hold is consumed -> nothing lost
    vt[7] = '{24'hA5A5A5, 24'h5A5A5A, 24'h0F0F0F, 3, 40, 138, 1'b0, 3, 16'hA5A5, 16'h5A5A, 16'h0F0F, 1'b0};
    // captures at the 138-cycle sample period
    vt[8] = '{24'h13579B, 24'h2468AC, 24'hFEDCBA, 3, 138, 276, 1'b0, 3, 16'h1357, 16'h2468, 16'hFEDC, 1'b0};

    // Reset held with data_valid toggling: no frame, outputs idle
    for (int k = 0; k < 5; k++) tick(1'b0, 1'(k % 2), 24'($urandom));
    repeat (20) tick(1'b1, 1'b0, 24'($urandom));
    check("no_frame_after_reset", 32'(obs.size()), 32'd0);

    // Table vectors
    for (int i = 0; i < NV; i++) begin
      repeat (2) tick(1'b0, 1'b0, 24'h0);
      repeat (3) tick(1'b1, 1'b0, 24'($urandom));
      obs.delete();
      span = vt[i].hold ? 1000 : ((vt[i].n > 2) ? vt[i].off2 : (vt[i].n > 1) ? vt[i].off1 : 0) + 1;
      for (int k = 0; k < span; k++) begin
        if (vt[i].hold) begin
          dv = 1'b1;
          d  = vt[i].d0;
        end else begin
          dv = (k == 0) || (vt[i].n > 1 && k == vt[i].off1) || (vt[i].n > 2 && k == vt[i].off2);
          if (k == 0) d = vt[i].d0;
          else if (vt[i].n > 1 && k == vt[i].off1) d = vt[i].d1;
          else if (vt[i].n > 2 && k == vt[i].off2) d = vt[i].d2;
          else d = 24'($urandom);
        end
        tick(1'b1, dv, d);
      end
      drain();
      check($sformatf("vec%0d_frames", i), 32'(obs.size()), 32'(vt[i].nexp));
      if (obs.size() > 0) check($sformatf("vec%0d_w0", i), 32'(obs[0]), 32'(tw(vt[i].w0)));
      if (vt[i].nexp > 1 && obs.size() > 1) check($sformatf("vec%0d_w1", i), 32'(obs[1]), 32'(tw(vt[i].w1)));
      if (vt[i].nexp > 2 && obs.size() > 2) check($sformatf("vec%0d_w2", i), 32'(obs[2]), 32'(tw(vt[i].w2)));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vt[i].ovr));
    end

    // Overrun stays set until reset, then clears
    repeat (2) tick(1'b1, 1'b0, 24'h0);
    repeat (1) tick(1'b0, 1'b0, 24'h0);
    check("overrun_cleared_by_reset", 32'(overrun), 32'd0);

    // Reset in the middle of a frame: frame aborted, held word discarded
    repeat (2) tick(1'b1, 1'b0, 24'h0);
    obs.delete();
    tick(1'b1, 1'b1, 24'h123456);
    repeat (40) tick(1'b1, 1'b0, 24'h0);
    tick(1'b1, 1'b1, 24'h654321);
    repeat (20) tick(1'b1, 1'b0, 24'h0);
    check("mid_frame_active", 32'(dac_sync_n), 32'd0);
    tick(1'b0, 1'b1, 24'h777777);
    repeat (300) tick(1'b1, 1'b0, 24'h0);
    check("no_frame_after_abort", 32'(obs.size()), 32'd0);

    // Random pulses and data against the model
    for (int c = 0; c < 60; c++) begin
      gap = int'($urandom_range(2, 200));
      wid = int'($urandom_range(1, 3));
      d   = 24'($urandom);
      for (int k = 0; k < gap; k++) tick(1'b1, 1'(k < wid), (k == 0) ? d : 24'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", ecount);
    $fatal(1);
  end

endmodule
